// File: rtl/host_wb_master_pkg.sv
// Shared constants for the host-bus to Wishbone master bridge:
// register map, CTRL/STAT bit positions and FSM encoding.
package host_wb_master_pkg;

    localparam int REG_CTRL    = 0;
    localparam int REG_ADR     = 1;
    localparam int REG_WDATA   = 2;
    localparam int REG_RDATA   = 3;
    localparam int REG_TIMEOUT = 4;

    localparam int CTRL_START   = 0;
    localparam int CTRL_WE      = 1;
    localparam int CTRL_SEL_LSB = 16;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_WE        = 1;
    localparam int STAT_DONE      = 2;
    localparam int STAT_ACKED     = 3;
    localparam int STAT_ERRED     = 4;
    localparam int STAT_TIMED_OUT = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

endpackage

// File: rtl/host_wb_master.sv
// Host-programmable single-cycle classic Wishbone master with err/ack/timeout
// status reporting and a registered host register interface.
module host_wb_master
    import host_wb_master_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_WIDTH   = 16,
    parameter int TIMEOUT_DEFAULT = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wren_i,
    input  logic                    rden_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    ack_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int SEL_W = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(REG_CTRL);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ADR     = ADDR_WIDTH'(REG_ADR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_WDATA   = ADDR_WIDTH'(REG_WDATA);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RDATA   = ADDR_WIDTH'(REG_RDATA);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TIMEOUT = ADDR_WIDTH'(REG_TIMEOUT);

    state_t                   state_reg;
    logic [DATA_WIDTH-1:0]    adr_reg;
    logic [DATA_WIDTH-1:0]    wdata_reg;
    logic [DATA_WIDTH-1:0]    rdata_reg;
    logic [TIMEOUT_WIDTH-1:0] timeout_reg;
    logic [TIMEOUT_WIDTH-1:0] count_reg;
    logic                     we_reg;
    logic [SEL_W-1:0]         sel_reg;
    logic                     done_reg;
    logic                     acked_reg;
    logic                     erred_reg;
    logic                     timed_out_reg;
    logic                     cyc_reg;
    logic                     wb_we_reg;
    logic [SEL_W-1:0]         wb_sel_reg;
    logic                     ack_reg;
    logic [DATA_WIDTH-1:0]    rd_data_reg;

    logic                     busy;
    logic                     host_wr;
    logic                     start;
    logic                     expired;
    logic [DATA_WIDTH-1:0]    stat_word;
    logic [DATA_WIDTH-1:0]    read_word;

    assign busy    = (state_reg == ST_BUS);
    assign host_wr = wren_i && !busy;
    assign start   = host_wr && (addr_i == ADDR_CTRL) && data_i[CTRL_START];
    // A loaded value of 0 never reaches 1, which is what disables the timeout.
    assign expired = (count_reg == TIMEOUT_WIDTH'(1));

    always_comb begin
        stat_word                          = '0;
        stat_word[STAT_BUSY]               = busy;
        stat_word[STAT_WE]                 = we_reg;
        stat_word[STAT_DONE]               = done_reg;
        stat_word[STAT_ACKED]              = acked_reg;
        stat_word[STAT_ERRED]              = erred_reg;
        stat_word[STAT_TIMED_OUT]          = timed_out_reg;
        stat_word[CTRL_SEL_LSB +: SEL_W]   = sel_reg;
        case (addr_i)
            ADDR_CTRL:    read_word = stat_word;
            ADDR_ADR:     read_word = adr_reg;
            ADDR_WDATA:   read_word = wdata_reg;
            ADDR_RDATA:   read_word = rdata_reg;
            ADDR_TIMEOUT: read_word = DATA_WIDTH'(timeout_reg);
            default:      read_word = '1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            adr_reg       <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            timeout_reg   <= TIMEOUT_WIDTH'(TIMEOUT_DEFAULT);
            count_reg     <= '0;
            we_reg        <= 1'b0;
            sel_reg       <= '0;
            done_reg      <= 1'b0;
            acked_reg     <= 1'b0;
            erred_reg     <= 1'b0;
            timed_out_reg <= 1'b0;
            cyc_reg       <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_sel_reg    <= '1;
            ack_reg       <= 1'b0;
            rd_data_reg   <= '0;
        end else begin
            ack_reg     <= rden_i | wren_i;
            rd_data_reg <= rden_i ? read_word : '0;

            if (host_wr) begin
                case (addr_i)
                    ADDR_ADR:     adr_reg     <= data_i;
                    ADDR_WDATA:   wdata_reg   <= data_i;
                    ADDR_TIMEOUT: timeout_reg <= data_i[TIMEOUT_WIDTH-1:0];
                    default:      ;
                endcase
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_BUS;
                        cyc_reg       <= 1'b1;
                        we_reg        <= data_i[CTRL_WE];
                        wb_we_reg     <= data_i[CTRL_WE];
                        sel_reg       <= data_i[CTRL_SEL_LSB +: SEL_W];
                        wb_sel_reg    <= data_i[CTRL_SEL_LSB +: SEL_W];
                        done_reg      <= 1'b0;
                        acked_reg     <= 1'b0;
                        erred_reg     <= 1'b0;
                        timed_out_reg <= 1'b0;
                        count_reg     <= timeout_reg;
                    end
                end
                ST_BUS: begin
                    // err wins over ack, ack wins over a coincident expiry
                    if (wb_err_i || wb_ack_i || expired) begin
                        state_reg     <= ST_IDLE;
                        cyc_reg       <= 1'b0;
                        wb_we_reg     <= 1'b0;
                        done_reg      <= 1'b1;
                        erred_reg     <= wb_err_i;
                        acked_reg     <= !wb_err_i && wb_ack_i;
                        timed_out_reg <= !wb_err_i && !wb_ack_i;
                        if (!wb_err_i && wb_ack_i && !we_reg) begin
                            rdata_reg <= wb_dat_i;
                        end
                    end else if (count_reg != '0) begin
                        count_reg <= count_reg - TIMEOUT_WIDTH'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ack_o    = ack_reg;
    assign data_o   = rd_data_reg;
    assign wb_cyc_o = cyc_reg;
    assign wb_stb_o = cyc_reg;
    assign wb_we_o  = wb_we_reg;
    assign wb_adr_o = adr_reg;
    assign wb_dat_o = wdata_reg;
    assign wb_sel_o = wb_sel_reg;

endmodule
